// File: rtl/dds_sweep_ctrl.sv
// rtl/dds_sweep_ctrl.sv - DDS frequency-word controller: debounced keys, manual step and triangle sweep
// Key events and the sweep FSM both drive freq_word through saturating 13-bit add/subtract.

module dds_key_deb #(
    parameter int DEB_CNT = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw,
    output logic press
);
    localparam int CW = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CNT - 1);

    logic          key_s1;
    logic          key_s2;
    logic          key_acc;
    logic          key_acc_d;
    logic [CW-1:0] cnt;

    // Idle level of a key is 1, so every stage comes out of reset released.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_s1    <= 1'b1;
            key_s2    <= 1'b1;
            key_acc   <= 1'b1;
            key_acc_d <= 1'b1;
            cnt       <= '0;
        end else begin
            key_s1    <= key_raw;
            key_s2    <= key_s1;
            key_acc_d <= key_acc;
            if (key_s2 == key_acc) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt     <= '0;
                key_acc <= key_s2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign press = key_acc_d & ~key_acc;
endmodule

module dds_sweep_ctrl #(
    parameter int          DEB_CNT = 500000,
    parameter int          DWELL   = 50000,
    parameter logic [11:0] STEP    = 12'd16,
    parameter logic [11:0] F_MIN   = 12'd1,
    parameter logic [11:0] F_MAX   = 12'd4095,
    parameter logic [11:0] F_INIT  = 12'd1
) (
    input  logic        sys_clk,
    input  logic        reset,
    input  logic        freq_add,
    input  logic        freq_dec,
    input  logic        sweep_en,
    input  logic [1:0]  switch,
    output logic [11:0] freq_word,
    output logic [1:0]  wave_sel,
    output logic        freq_upd,
    output logic        sweep_busy
);
    localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);

    typedef enum logic [1:0] {
        MANUAL     = 2'd0,
        SWEEP_UP   = 2'd1,
        SWEEP_DOWN = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [DW-1:0] dwell_cnt;
    logic [DW-1:0] dwell_nxt;
    logic [11:0]   fw_nxt;
    logic [12:0]   fw_sum;
    logic [11:0]   fw_up;
    logic [11:0]   fw_dn;
    logic          add_press;
    logic          dec_press;
    logic          sweep_s1;
    logic          sweep_s2;
    logic [1:0]    sw_s1;
    logic [1:0]    sw_s2;

    dds_key_deb #(.DEB_CNT(DEB_CNT)) u_deb_add (
        .clk     (sys_clk),
        .rst_n   (reset),
        .key_raw (freq_add),
        .press   (add_press)
    );

    dds_key_deb #(.DEB_CNT(DEB_CNT)) u_deb_dec (
        .clk     (sys_clk),
        .rst_n   (reset),
        .key_raw (freq_dec),
        .press   (dec_press)
    );

    // Both directions saturate in 13 bits so the word can never wrap past a limit.
    always_comb begin
        fw_sum = {1'b0, freq_word} + {1'b0, STEP};
        fw_up  = (fw_sum > {1'b0, F_MAX}) ? F_MAX : fw_sum[11:0];
        fw_dn  = ({1'b0, freq_word} < ({1'b0, F_MIN} + {1'b0, STEP})) ? F_MIN : (freq_word - STEP);
    end

    always_comb begin
        state_nxt = state;
        dwell_nxt = dwell_cnt;
        fw_nxt    = freq_word;
        case (state)
            MANUAL: begin
                if (add_press && !dec_press) begin
                    fw_nxt = fw_up;
                end else if (dec_press && !add_press) begin
                    fw_nxt = fw_dn;
                end
                if (sweep_s2) begin
                    state_nxt = SWEEP_UP;
                    dwell_nxt = '0;
                end
            end
            SWEEP_UP: begin
                if (!sweep_s2) begin
                    state_nxt = MANUAL;
                end else if (dwell_cnt == DWELL_LAST) begin
                    dwell_nxt = '0;
                    fw_nxt    = fw_up;
                    if (fw_up == F_MAX) state_nxt = SWEEP_DOWN;
                end else begin
                    dwell_nxt = dwell_cnt + 1'b1;
                end
            end
            SWEEP_DOWN: begin
                if (!sweep_s2) begin
                    state_nxt = MANUAL;
                end else if (dwell_cnt == DWELL_LAST) begin
                    dwell_nxt = '0;
                    fw_nxt    = fw_dn;
                    if (fw_dn == F_MIN) state_nxt = SWEEP_UP;
                end else begin
                    dwell_nxt = dwell_cnt + 1'b1;
                end
            end
            default: state_nxt = MANUAL;
        endcase
    end

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            state     <= MANUAL;
            dwell_cnt <= '0;
            freq_word <= F_INIT;
            freq_upd  <= 1'b0;
            wave_sel  <= 2'b00;
            sweep_s1  <= 1'b0;
            sweep_s2  <= 1'b0;
            sw_s1     <= 2'b00;
            sw_s2     <= 2'b00;
        end else begin
            state     <= state_nxt;
            dwell_cnt <= dwell_nxt;
            freq_word <= fw_nxt;
            freq_upd  <= (fw_nxt != freq_word);
            wave_sel  <= sw_s2;
            sweep_s1  <= sweep_en;
            sweep_s2  <= sweep_s1;
            sw_s1     <= switch;
            sw_s2     <= sw_s1;
        end
    end

    assign sweep_busy = (state != MANUAL);
endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// tb/tb_dds_sweep_ctrl.sv - self-checking bench for dds_sweep_ctrl
// A history-window reference model is compared every cycle; directed literals pin the model.

module tb_dds_sweep_ctrl;
    localparam int DEB  = 4;
    localparam int DWL  = 3;
    localparam int STP  = 16;
    localparam int FMIN = 1;
    localparam int FMAX = 64;
    localparam int FINI = 1;

    logic        sys_clk;
    logic        reset;
    logic        freq_add;
    logic        freq_dec;
    logic        sweep_en;
    logic [1:0]  switch;
    logic [11:0] freq_word;
    logic [1:0]  wave_sel;
    logic        freq_upd;
    logic        sweep_busy;

    int checks   = 0;
    int failures = 0;
    bit chk_on   = 1'b0;
    int cyc      = 0;
    int upd_cnt  = 0;
    int upd_q[$];
    int upd_t[$];

    dds_sweep_ctrl #(
        .DEB_CNT (DEB),
        .DWELL   (DWL),
        .STEP    (12'd16),
        .F_MIN   (12'd1),
        .F_MAX   (12'd64),
        .F_INIT  (12'd1)
    ) dut (
        .sys_clk    (sys_clk),
        .reset      (reset),
        .freq_add   (freq_add),
        .freq_dec   (freq_dec),
        .sweep_en   (sweep_en),
        .switch     (switch),
        .freq_word  (freq_word),
        .wave_sel   (wave_sel),
        .freq_upd   (freq_upd),
        .sweep_busy (sweep_busy)
    );

    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: sync value seen at an edge is the raw input sampled two edges earlier;
    // a key level flips once DEB consecutive sync samples disagree with it.
    logic [15:0] add_h;
    logic [15:0] dec_h;
    logic [15:0] swp_h;
    logic [1:0]  sw_h [3];
    logic        acc_add;
    logic        acc_dec;
    logic        pend_add;
    logic        pend_dec;
    logic        m_upd;
    logic [1:0]  m_ws;
    int          m_fw;
    int          m_mode;
    int          next_step;
    int          ecnt;
    int          nfw;

    function automatic int sat_up(input int v);
        return (v + STP > FMAX) ? FMAX : v + STP;
    endfunction

    function automatic int sat_dn(input int v);
        return (v - STP < FMIN) ? FMIN : v - STP;
    endfunction

    function automatic logic flips(input logic [15:0] h, input logic acc);
        logic ok;
        ok = 1'b1;
        for (int i = 2; i < 2 + DEB; i++) if (h[i] == acc) ok = 1'b0;
        return ok;
    endfunction

    always @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            add_h = '1; dec_h = '1; swp_h = '0;
            sw_h[0] = 2'b00; sw_h[1] = 2'b00; sw_h[2] = 2'b00;
            acc_add = 1'b1; acc_dec = 1'b1; pend_add = 1'b0; pend_dec = 1'b0;
            m_fw = FINI; m_mode = 0; m_upd = 1'b0; m_ws = 2'b00; next_step = 0; ecnt = 0;
        end else begin
            ecnt++;
            add_h = {add_h[14:0], freq_add};
            dec_h = {dec_h[14:0], freq_dec};
            swp_h = {swp_h[14:0], sweep_en};
            sw_h[2] = sw_h[1]; sw_h[1] = sw_h[0]; sw_h[0] = switch;
            nfw = m_fw;
            if (m_mode == 0) begin
                if (pend_add && !pend_dec) nfw = sat_up(m_fw);
                else if (pend_dec && !pend_add) nfw = sat_dn(m_fw);
                if (swp_h[2]) begin
                    m_mode = 1;
                    next_step = ecnt + DWL;
                end
            end else if (!swp_h[2]) begin
                m_mode = 0;
            end else if (ecnt == next_step) begin
                next_step = ecnt + DWL;
                if (m_mode == 1) begin
                    nfw = sat_up(m_fw);
                    if (nfw == FMAX) m_mode = 2;
                end else begin
                    nfw = sat_dn(m_fw);
                    if (nfw == FMIN) m_mode = 1;
                end
            end
            m_upd = (nfw != m_fw);
            m_fw  = nfw;
            pend_add = 1'b0;
            if (flips(add_h, acc_add)) begin
                acc_add  = ~acc_add;
                pend_add = ~acc_add;
            end
            pend_dec = 1'b0;
            if (flips(dec_h, acc_dec)) begin
                acc_dec  = ~acc_dec;
                pend_dec = ~acc_dec;
            end
            m_ws = sw_h[2];
        end
    end

    always @(posedge sys_clk) cyc++;

    always @(negedge sys_clk) begin
        if (freq_upd === 1'b1) begin
            upd_cnt++;
            upd_q.push_back(int'(freq_word));
            upd_t.push_back(cyc);
        end
        if (chk_on) begin
            chk("cyc_freq_word", 32'(freq_word), 32'(m_fw));
            chk("cyc_freq_upd", 32'(freq_upd), 32'(m_upd));
            chk("cyc_sweep_busy", 32'(sweep_busy), 32'(m_mode != 0));
            chk("cyc_wave_sel", 32'(wave_sel), 32'(m_ws));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic press(input logic a, input logic d, input int hold);
        @(posedge sys_clk); #1;
        if (a) freq_add = 1'b0;
        if (d) freq_dec = 1'b0;
        tick(hold);
        freq_add = 1'b1;
        freq_dec = 1'b1;
        tick(12);
    endtask

    int base;
    int q0;
    bit reached;
    int exp_sweep [10] = '{17, 33, 49, 64, 48, 32, 16, 1, 17, 33};

    initial begin
        reset = 1'b0; freq_add = 1'b1; freq_dec = 1'b1; sweep_en = 1'b0; switch = 2'b00;
        tick(2);
        chk("rst_freq_word", 32'(freq_word), 32'd1);
        chk("rst_freq_upd", 32'(freq_upd), 32'd0);
        chk("rst_sweep_busy", 32'(sweep_busy), 32'd0);
        chk("rst_wave_sel", 32'(wave_sel), 32'd0);
        chk_on = 1'b1;
        reset = 1'b1;
        tick(2);

        base = upd_cnt;
        press(1'b1, 1'b0, 10);
        chk("add_first", 32'(freq_word), 32'd17);
        chk("add_first_upd", 32'(upd_cnt - base), 32'd1);
        press(1'b1, 1'b0, 10);
        chk("add_second", 32'(freq_word), 32'd33);

        base = upd_cnt;
        press(1'b1, 1'b0, 3);
        chk("glitch_word", 32'(freq_word), 32'd33);
        press(1'b1, 1'b1, 10);
        chk("both_word", 32'(freq_word), 32'd33);
        chk("glitch_both_upd", 32'(upd_cnt - base), 32'd0);

        press(1'b1, 1'b0, 10);
        chk("add_to_49", 32'(freq_word), 32'd49);
        base = upd_cnt;
        press(1'b1, 1'b0, 10);
        chk("add_to_max", 32'(freq_word), 32'd64);
        press(1'b1, 1'b0, 10);
        chk("add_sat_max", 32'(freq_word), 32'd64);
        chk("sat_max_upd", 32'(upd_cnt - base), 32'd1);

        for (int i = 0; i < 4; i++) press(1'b0, 1'b1, 10);
        chk("dec_to_min", 32'(freq_word), 32'd1);
        base = upd_cnt;
        press(1'b0, 1'b1, 10);
        chk("dec_sat_min", 32'(freq_word), 32'd1);
        chk("sat_min_upd", 32'(upd_cnt - base), 32'd0);

        q0 = upd_q.size();
        sweep_en = 1'b1;
        tick(5);
        freq_add = 1'b0; tick(8); freq_add = 1'b1;
        freq_dec = 1'b0; tick(8); freq_dec = 1'b1;
        reached = 1'b0;
        for (int i = 0; i < 200 && !reached; i++) begin
            @(posedge sys_clk); #2;
            if (upd_q.size() >= q0 + 9) reached = 1'b1;
        end
        chk("sweep_reach_ninth", 32'(reached), 32'd1);
        chk("sweep_busy_on", 32'(sweep_busy), 32'd1);
        sweep_en = 1'b0;
        tick(20);
        chk("sweep_step_count", 32'(upd_q.size() - q0), 32'd10);
        for (int i = 0; i < 10; i++)
            if (q0 + i < upd_q.size()) chk($sformatf("sweep_val%0d", i), 32'(upd_q[q0 + i]), 32'(exp_sweep[i]));
        for (int i = 1; i < 10; i++)
            if (q0 + i < upd_t.size()) chk($sformatf("sweep_gap%0d", i), 32'(upd_t[q0 + i] - upd_t[q0 + i - 1]), 32'd3);
        chk("exit_word", 32'(freq_word), 32'd33);
        chk("exit_busy", 32'(sweep_busy), 32'd0);

        switch = 2'b01;
        sweep_en = 1'b1;
        tick(8);
        chk("pre_rst_wave_sel", 32'(wave_sel), 32'd1);
        chk("pre_rst_busy", 32'(sweep_busy), 32'd1);
        freq_add = 1'b0;
        tick(3);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_word", 32'(freq_word), 32'd1);
        chk("mid_rst_upd", 32'(freq_upd), 32'd0);
        chk("mid_rst_busy", 32'(sweep_busy), 32'd0);
        chk("mid_rst_wave_sel", 32'(wave_sel), 32'd0);
        tick(2);
        sweep_en = 1'b0;
        reset = 1'b1;
        base = upd_cnt;
        tick(12);
        chk("held_key_press", 32'(freq_word), 32'd17);
        freq_add = 1'b1;
        tick(12);
        chk("held_key_once", 32'(upd_cnt - base), 32'd1);

        @(posedge sys_clk); #1;
        switch = 2'b10;
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        chk("wave_sel_lat2", 32'(wave_sel), 32'd1);
        @(posedge sys_clk);
        @(negedge sys_clk);
        chk("wave_sel_lat3", 32'(wave_sel), 32'd2);
        tick(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
